// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: display-priority single-port frame RAM arbiter with buffered NPU writes; OOB_CHECK_EN adds an address range check and oob_err
module frame_ram_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int IMG_PIXELS = 160000
) (
  input  logic                          clk_25,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic [DATA_W-1:0]             disp_data,
  output logic                          disp_valid,
  input  logic                          npu_wr_valid,
  input  logic [ADDR_W-1:0]             npu_wr_addr,
  input  logic [DATA_W-1:0]             npu_wr_data,
  output logic                          npu_wr_ready,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic                          ram_we,
  input  logic [DATA_W-1:0]             ram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done
`ifdef OOB_CHECK_EN
  ,
  output logic                          oob_err
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(IMG_PIXELS + 1);
  localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(IMG_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic ram_we_q, ram_we_d, disp_valid_q, disp_valid_d;
  logic accept, keep, push, pop;

  assign npu_wr_ready = level_q != FULL;
  assign accept = npu_wr_valid & npu_wr_ready;
  assign push = accept & keep;

`ifdef OOB_CHECK_EN
  localparam logic [ADDR_W:0] IMG_A = (ADDR_W + 1)'(IMG_PIXELS);
  logic oob_err_q, oob_err_d;
  assign keep = {1'b0, npu_wr_addr} < IMG_A;
  assign oob_err_d = oob_err_q | (accept & ~keep);
  assign oob_err = oob_err_q;
  always_ff @(posedge clk_25) begin
    oob_err_q <= rst ? 1'b0 : oob_err_d;
  end
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clk_25) begin
    state_q <= rst ? IDLE : state_d;
  end

  always_comb begin
    state_d = disp_req ? READ : (level_q != '0) ? WRITE : IDLE;
  end

  always_comb begin
    pop = state_d == WRITE;
    ram_we_d = pop;
    ram_addr_d = (state_d == READ) ? disp_addr : pop ? fifo_addr_q[rd_ptr_q] : ram_addr_q;
    ram_wdata_d = pop ? fifo_data_q[rd_ptr_q] : ram_wdata_q;
    disp_valid_d = state_q == READ;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d = (push && !pop) ? level_q + (PW + 1)'(1) : (pop && !push) ? level_q - (PW + 1)'(1) : level_q;
    cnt_d = !ram_we_q ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      ram_we_q <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q <= ram_we_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  always_ff @(posedge clk_25) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= npu_wr_addr;
      fifo_data_q[wr_ptr_q] <= npu_wr_data;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data = disp_valid_q ? ram_rdata : '0;
  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we = ram_we_q;
  assign fifo_level = level_q;
  assign frame_done = ram_we_q && (cnt_q == LAST);
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: vector table, directed corner sequences and random traffic against a queue-based model
module tb_frame_ram_arbiter;
  localparam int AW = 19, DW = 8, D = 8, IMG = 40;
  logic clk_25 = 1'b0;
  logic rst = 1'b1, disp_req = 1'b0, npu_wr_valid = 1'b0;
  logic [AW-1:0] disp_addr = '0, npu_wr_addr = '0;
  logic [DW-1:0] npu_wr_data = '0;
  logic [DW-1:0] disp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic disp_valid, npu_wr_ready, ram_we, frame_done;
  logic [3:0] fifo_level;
`ifdef OOB_CHECK_EN
  logic oob_err;
`endif

  always #20 clk_25 = ~clk_25;

  frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .IMG_PIXELS(IMG)) dut (
    .clk_25(clk_25), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .npu_wr_valid(npu_wr_valid), .npu_wr_addr(npu_wr_addr), .npu_wr_data(npu_wr_data),
    .npu_wr_ready(npu_wr_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .fifo_level(fifo_level), .frame_done(frame_done)
`ifdef OOB_CHECK_EN
    , .oob_err(oob_err)
`endif
  );

  function automatic logic [7:0] init_val(int a);
    return a == 16 ? 8'hA5 : a == 32 ? 8'h3C : a == 7 ? 8'h42 : 8'(a * 37 + 5);
  endfunction

  logic [7:0] ram [256];
  bit ram_init = 1'b0;
  always @(posedge clk_25) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[7:0]];
  end

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wq[$];
  wr_t e_wr;
  logic [7:0] shadow [256];
  logic [7:0] e_rd;
  logic e_we = 0, e_valid = 0, e_frame = 0, e_ready = 1, e_oob = 0, s1 = 0;
  logic [AW-1:0] s1_addr, last_addr = '0;
  int e_level = 0, cnt = 0, total = 0, bad = 0, we_seen = 0, frames = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic r = rst, q = disp_req, v = npu_wr_valid;
    logic [AW-1:0] qa = disp_addr;
    wr_t w = {npu_wr_addr, npu_wr_data};
    int qb;
    @(posedge clk_25);
    if (e_we) shadow[e_wr.a[7:0]] = e_wr.d;
    if (r) begin
      wq.delete();
      e_we = 0; e_valid = 0; e_frame = 0; s1 = 0; cnt = 0; e_oob = 0;
    end else begin
      e_valid = s1;
      e_rd = shadow[s1_addr[7:0]];
      s1 = q;
      s1_addr = qa;
      qb = wq.size();
      e_we = !q && qb > 0;
      if (e_we) e_wr = wq.pop_front();
      if (v && qb < D) begin
`ifdef OOB_CHECK_EN
        if (w.a >= IMG) e_oob = 1; else wq.push_back(w);
`else
        wq.push_back(w);
`endif
      end
      e_frame = 0;
      if (e_we) begin
        cnt++;
        if (cnt == IMG) begin e_frame = 1; cnt = 0; end
      end
    end
    e_level = wq.size();
    e_ready = e_level < D;
    @(negedge clk_25);
    chk("ram_we", ram_we, e_we);
    chk("disp_valid", disp_valid, e_valid);
    chk("fifo_level", fifo_level, e_level);
    chk("npu_wr_ready", npu_wr_ready, e_ready);
    chk("frame_done", frame_done, e_frame);
    if (e_we) begin
      chk("commit_addr", ram_addr, e_wr.a);
      chk("commit_data", ram_wdata, e_wr.d);
    end
    if (s1) chk("read_addr", ram_addr, s1_addr);
    if (e_valid) chk("disp_data", disp_data, e_rd);
`ifdef OOB_CHECK_EN
    chk("oob_err", oob_err, e_oob);
`endif
    if (ram_we) begin
      we_seen++;
      last_addr = ram_addr;
      if (frame_done) frames++;
    end
  endtask

  typedef struct {
    logic rst, req; logic [AW-1:0] ra; logic wv; logic [AW-1:0] wa; logic [7:0] wd;
    logic xv; logic [7:0] xd; logic xwe, xrdy; int xlvl;
  } vec_t;
  vec_t vt[13];

  initial begin
    int w0, f0, idx;
    logic rdy;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    vt[0]  = '{1, 0, 0,     0, 0, 0,     0, 0,     0, 1, 0};
    vt[1]  = '{1, 0, 0,     0, 0, 0,     0, 0,     0, 1, 0};
    vt[2]  = '{0, 1, 'h10,  0, 0, 0,     0, 0,     0, 1, 0};
    vt[3]  = '{0, 0, 0,     0, 0, 0,     1, 'hA5,  0, 1, 0};
    vt[4]  = '{0, 0, 0,     0, 0, 0,     0, 0,     0, 1, 0};
    vt[5]  = '{0, 1, 'h20,  1, 5, 'h11,  0, 0,     0, 1, 1};
    vt[6]  = '{0, 0, 0,     0, 0, 0,     1, 'h3C,  1, 1, 0};
    vt[7]  = '{0, 0, 0,     0, 0, 0,     0, 0,     0, 1, 0};
    vt[8]  = '{0, 1, 7,     1, 7, 'h99,  0, 0,     0, 1, 1};
    vt[9]  = '{0, 0, 0,     0, 0, 0,     1, 'h42,  1, 1, 0};
    vt[10] = '{0, 1, 7,     0, 0, 0,     0, 0,     0, 1, 0};
    vt[11] = '{0, 0, 0,     0, 0, 0,     1, 'h99,  0, 1, 0};
    vt[12] = '{0, 0, 0,     0, 0, 0,     0, 0,     0, 1, 0};
    foreach (vt[i]) begin
      rst = vt[i].rst; disp_req = vt[i].req; disp_addr = vt[i].ra;
      npu_wr_valid = vt[i].wv; npu_wr_addr = vt[i].wa; npu_wr_data = vt[i].wd;
      tick();
      chk($sformatf("vec%0d.valid", i), disp_valid, vt[i].xv);
      if (vt[i].xv) chk($sformatf("vec%0d.data", i), disp_data, vt[i].xd);
      chk($sformatf("vec%0d.we", i), ram_we, vt[i].xwe);
      chk($sformatf("vec%0d.ready", i), npu_wr_ready, vt[i].xrdy);
      chk($sformatf("vec%0d.level", i), fifo_level, vt[i].xlvl);
    end

    for (int i = 0; i < D; i++) begin
      disp_req = 1; disp_addr = AW'(i); npu_wr_valid = 1;
      npu_wr_addr = AW'(i + 8); npu_wr_data = 8'(8'hC0 + i);
      tick();
    end
    chk("full_level", fifo_level, D);
    chk("full_ready", npu_wr_ready, 0);
    npu_wr_addr = AW'(50); npu_wr_data = 8'hEE;
    tick();
    chk("full_hold_level", fifo_level, D);
    chk("full_hold_we", ram_we, 0);
    w0 = we_seen;
    disp_req = 0;
    tick();
    chk("pop_at_full_level", fifo_level, D - 1);
    tick();
    chk("push_pop_level", fifo_level, D - 1);
    npu_wr_valid = 0;
    repeat (10) tick();
    chk("drain_we_count", we_seen - w0, D + 1);
    chk("drain_level", fifo_level, 0);

    rst = 1; tick(); tick(); rst = 0;
    w0 = we_seen; f0 = frames; idx = 0;
    for (int k = 0; k < 4 * IMG + 20 && we_seen - w0 < 2 * IMG; k++) begin
      npu_wr_valid = idx < 2 * IMG;
      npu_wr_addr = AW'(idx % IMG);
      npu_wr_data = 8'($urandom);
      rdy = npu_wr_ready;
      tick();
      if (npu_wr_valid && rdy) idx++;
    end
    npu_wr_valid = 0;
    chk("stream_we_count", we_seen - w0, 2 * IMG);
    chk("stream_frames", frames - f0, 2);

    npu_wr_valid = 1; npu_wr_addr = AW'(IMG); npu_wr_data = 8'h5A;
    tick();
    npu_wr_valid = 0;
    repeat (3) tick();
`ifdef OOB_CHECK_EN
    chk("oob_sticky", oob_err, 1);
    chk("oob_not_committed", last_addr == AW'(IMG), 0);
    rst = 1; tick(); rst = 0;
    chk("oob_cleared", oob_err, 0);
`else
    chk("oob_committed", last_addr, IMG);
`endif

    for (int k = 0; k < 1500; k++) begin
      int p;
      p = ((k / 100) % 3 == 0) ? 90 : ((k / 100) % 3 == 1) ? 50 : 10;
      rst = $urandom_range(199) == 0;
      disp_req = $urandom_range(99) < p;
      disp_addr = AW'($urandom_range(63));
      npu_wr_valid = $urandom_range(99) < 60;
      npu_wr_addr = AW'($urandom_range(63));
      npu_wr_data = 8'($urandom);
      tick();
    end
    rst = 0; disp_req = 0; npu_wr_valid = 0;
    repeat (12) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
